// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// This block sequences load, store and copy requests from the processor
// datapath into the 16x8 data RAM. It also absorbs the RAM's one-cycle
// registered read latency.
//
// Ports
//   clock, reset           system clock; synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op                 00 load, 01 store, 10 copy, 11 reserved (error)
//   req_addr, req_addr2    load/store/copy-source address, copy destination
//   req_wdata              store data
//   rsp_valid/rsp_ready    response handshake; held until accepted
//   rsp_rdata, rsp_err     response payload (0 data for store/error)
//   txn_count              completed responses, saturating at 255
//   ram_address, ram_dataIn, ram_we, ram_rd   RAM drive
//   ram_dataOut            RAM read data, valid the cycle after ram_rd
module mem_req_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        txn_count,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_we,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_dataOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  state_t            state, state_nxt;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q, addr2_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;      // RAM read data captured at end of RD_WAIT
  logic [7:0]        txn_count_q;
  logic              accept;
  logic              rsp_done;

  assign accept    = req_valid & req_ready;
  assign rsp_done  = rsp_valid & rsp_ready;
  assign txn_count = txn_count_q;

  // Next state and all outputs are decoded from the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    ram_we      = 1'b0;
    ram_rd      = 1'b0;
    ram_address = '0;
    ram_dataIn  = '0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (op_t'(req_op))
            OP_LOAD, OP_COPY: state_nxt = S_RD;
            OP_STORE:         state_nxt = S_WR;
            default:          state_nxt = S_RESP;
          endcase
        end
      end
      S_RD: begin
        ram_rd      = 1'b1;
        ram_address = addr_q;
        state_nxt   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        ram_address = addr_q;
        state_nxt   = (op_q == OP_COPY) ? S_WR : S_RESP;
      end
      S_WR: begin
        ram_we = 1'b1;
        if (op_q == OP_COPY) begin
          ram_address = addr2_q;
          ram_dataIn  = data_q;
        end else begin
          ram_address = addr_q;
          ram_dataIn  = wdata_q;
        end
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Reset is synchronous, so the state register can still hold a busy
    // state during the reset cycle. Gate everything so that a pending
    // write never reaches the RAM and no response leaks out.
    if (reset) begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      ram_we      = 1'b0;
      ram_rd      = 1'b0;
      ram_address = '0;
      ram_dataIn  = '0;
    end
  end

  // The response payload is derived from registers that are frozen in
  // RESP, so it stays stable under back-pressure.
  assign rsp_rdata = (rsp_valid && (op_q == OP_LOAD || op_q == OP_COPY)) ? data_q : '0;
  assign rsp_err   = rsp_valid && (op_q == OP_RSVD);

  // Control state.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register sees the pre-edge values of the others.
    if (reset) begin
      state       <= S_IDLE;
      txn_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (rsp_done && txn_count_q != 8'hFF) txn_count_q <= txn_count_q + 8'd1;
    end
  end

  // Request payload and read capture.
  // NOTE: these registers are deliberately left without reset. They are
  // only observed through state-qualified outputs, and each one is written
  // before it is used in any transaction.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q    <= op_t'(req_op);
      addr_q  <= req_addr;
      addr2_q <= req_addr2;
      wdata_q <= req_wdata;
    end
    if (state == S_RD_WAIT) data_q <= ram_dataOut;
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl. A behavioural 16x8 RAM with a
// registered read is attached to the DUT. A word-array reference model
// predicts the response data, latency, RAM activity and transaction count.
module tb_mem_req_ctrl;

  localparam logic [1:0] LOAD = 2'b00, STORE = 2'b01, COPY = 2'b10, RSVD = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_addr = 4'h0, req_addr2 = 4'h0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [7:0] txn_count;
  logic [3:0] ram_address;
  logic [7:0] ram_dataIn;
  logic       ram_we, ram_rd;
  logic [7:0] ram_dataOut;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [16];
  int         exp_count;

  always #5 clock = ~clock;

  mem_req_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_addr2   (req_addr2),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .txn_count   (txn_count),
    .ram_address (ram_address),
    .ram_dataIn  (ram_dataIn),
    .ram_we      (ram_we),
    .ram_rd      (ram_rd),
    .ram_dataOut (ram_dataOut)
  );

  // Behavioural data RAM: it has a registered read, and on reset it loads
  // F0,0F,01,02 into words 0..3 and clears the remaining words.
  logic [7:0] ram_mem [16];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
      ram_mem[0]  <= 8'hF0;
      ram_mem[1]  <= 8'h0F;
      ram_mem[2]  <= 8'h01;
      ram_mem[3]  <= 8'h02;
      ram_dataOut <= 8'h00;
    end else begin
      if (ram_we) ram_mem[ram_address] <= ram_dataIn;
      if (ram_rd) ram_dataOut <= ram_mem[ram_address];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'hF0;
    ref_mem[1] = 8'h0F;
    ref_mem[2] = 8'h01;
    ref_mem[3] = 8'h02;
    exp_count = 0;
  endtask

  // Hold reset for two edges and check the outputs while it is asserted.
  // Then release it and check the idle state one cycle later.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clock);
    check("rst_req_ready_low", req_ready, 0);
    check("rst_ram_we",        ram_we, 0);
    check("rst_ram_rd",        ram_rd, 0);
    @(negedge clock);
    reset = 1'b0;
    ref_reset();
    @(negedge clock);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_rsp_rdata", rsp_rdata, 0);
    check("post_rst_rsp_err",   rsp_err, 0);
    check("post_rst_txn_count", txn_count, 0);
    check("post_rst_ram_bus",   {ram_we, ram_rd, ram_address, ram_dataIn}, 0);
  endtask

  // Runs one transaction, starting and ending at a negedge. hold is the
  // number of RESP cycles spent with rsp_ready low; a junk request is
  // offered during those cycles.
  task automatic do_txn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] a2,
                        input logic [7:0] wd, input int hold);
    int         cyc, lat, we_n, rd_n, we_cyc, rd_cyc, exp_lat;
    logic [3:0] we_a, rd_a;
    logic [7:0] we_d, exp_d, src;
    logic       both, exp_e;

    // Reference model: latency, response payload and new memory contents.
    src   = ref_mem[a];
    exp_e = (op == RSVD);
    case (op)
      LOAD:    begin exp_lat = 3; exp_d = src; end
      STORE:   begin exp_lat = 2; exp_d = 8'h00; end
      COPY:    begin exp_lat = 4; exp_d = src; end
      default: begin exp_lat = 1; exp_d = 8'h00; end
    endcase

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_addr2 = a2; req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clock);                       // accept edge
    @(negedge clock);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 4'($urandom); req_addr2 = 4'($urandom);
    req_wdata = 8'($urandom);

    cyc = 1; we_n = 0; rd_n = 0; we_cyc = 0; rd_cyc = 0; both = 1'b0;
    we_a = 4'h0; rd_a = 4'h0; we_d = 8'h00;
    forever begin
      if (ram_we) begin we_n++; we_cyc = cyc; we_a = ram_address; we_d = ram_dataIn; end
      if (ram_rd) begin rd_n++; rd_cyc = cyc; rd_a = ram_address; end
      if (ram_we && ram_rd) both = 1'b1;
      if (rsp_valid || cyc >= 12) break;
      @(negedge clock);
      cyc++;
    end
    lat = rsp_valid ? cyc : 0;

    check("rsp_latency", lat, exp_lat);
    check("rsp_rdata",   rsp_rdata, exp_d);
    check("rsp_err",     rsp_err, exp_e);
    check("ram_we_rd_together", both, 0);
    check("ram_rd_cycles", rd_n, (op == LOAD || op == COPY) ? 1 : 0);
    check("ram_we_cycles", we_n, (op == STORE || op == COPY) ? 1 : 0);
    if (op == LOAD || op == COPY) begin
      check("ram_rd_cycle", rd_cyc, 1);
      check("ram_rd_addr",  rd_a, a);
    end
    if (op == STORE) begin
      check("ram_we_cycle", we_cyc, 1);
      check("ram_we_addr",  we_a, a);
      check("ram_we_data",  we_d, wd);
    end
    if (op == COPY) begin
      check("ram_we_cycle", we_cyc, 3);
      check("ram_we_addr",  we_a, a2);
      check("ram_we_data",  we_d, src);
    end

    // Back-pressure: the response is frozen and new requests are ignored.
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = 2'($urandom); req_addr = 4'($urandom);
      req_addr2 = 4'($urandom); req_wdata = 8'($urandom);
      @(negedge clock);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, exp_d);
      check("hold_rsp_err",   rsp_err, exp_e);
      check("hold_req_ready", req_ready, 0);
      check("hold_txn_count", txn_count, exp_count);
      check("hold_ram_idle",  {ram_we, ram_rd}, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;

    // Commit the transaction in the model.
    if (op == STORE) ref_mem[a] = wd;
    if (op == COPY)  ref_mem[a2] = src;
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;

    @(negedge clock);                       // handshake edge has passed
    check("done_rsp_valid", rsp_valid, 0);
    check("done_req_ready", req_ready, 1);
    check("done_txn_count", txn_count, exp_count);
  endtask

  // A store is accepted, and reset is asserted during its WR cycle. The
  // write must never reach the RAM.
  task automatic store_reset_in_wr(input logic [3:0] a, input logic [7:0] wd);
    check("rwr_req_ready", req_ready, 1);
    req_valid = 1'b1; req_op = STORE; req_addr = a; req_addr2 = 4'h0; req_wdata = wd;
    rsp_ready = 1'b1;
    @(posedge clock);                       // accept edge
    #1;
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clock);                       // WR cycle under reset
    check("rwr_ram_we",    ram_we, 0);
    check("rwr_rsp_valid", rsp_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    ref_reset();
    @(negedge clock);
    check("rwr_req_ready_after", req_ready, 1);
    check("rwr_rsp_valid_after", rsp_valid, 0);
    check("rwr_txn_count",       txn_count, 0);
  endtask

  initial begin
    logic [1:0] op;
    int         hold;

    ref_reset();
    apply_reset();

    // Load word 1 (expected 0x0F) with rsp_ready high.
    do_txn(LOAD, 4'd1, 4'd0, 8'h00, 0);
    // Store then reload.
    do_txn(STORE, 4'd5, 4'd0, 8'hA5, 0);
    do_txn(LOAD, 4'd5, 4'd0, 8'h00, 0);
    // Copy 0 -> 9, then reload the destination.
    do_txn(COPY, 4'd0, 4'd9, 8'h00, 0);
    do_txn(LOAD, 4'd9, 4'd0, 8'h00, 0);
    // Reserved op reports an error with no RAM activity.
    do_txn(RSVD, 4'd6, 4'd7, 8'h3C, 0);
    // Back-pressured load of word 3.
    do_txn(LOAD, 4'd3, 4'd0, 8'h00, 5);
    // Copy onto itself leaves the word unchanged.
    do_txn(COPY, 4'd7, 4'd7, 8'h00, 1);
    do_txn(LOAD, 4'd7, 4'd0, 8'h00, 0);

    // Reset during the WR cycle, followed by a load that sees the reset value.
    store_reset_in_wr(4'd2, 8'h77);
    do_txn(LOAD, 4'd2, 4'd0, 8'h00, 0);
    check("rwr_txn_count_load_only", txn_count, 1);

    // Random traffic. The run is long enough to reach txn_count saturation.
    for (int t = 0; t < 280; t++) begin
      op   = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      do_txn(op, 4'($urandom), 4'($urandom), 8'($urandom), hold);
    end
    check("txn_count_saturated", txn_count, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
